// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encodings and STEPS legality.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit n set means STEPS == n bit-steps per clock is a supported configuration.
  localparam logic [4:0] STEPS_LEGAL_MASK = 5'b10110;

  // True when STEPS is one of the supported values and divides WIDTH evenly.
  function automatic logic steps_ok(input int width, input int steps);
    return (((STEPS_LEGAL_MASK >> steps) & 5'd1) != 5'd0) && ((width % steps) == 0);
  endfunction

endpackage

// File: rtl/divmod.sv
// One restoring-division bit-step: shift one dividend bit into the partial remainder, subtract if it fits.
// Latency: purely combinational, chained STEPS deep inside div_iter.
// Backpressure: none; no handshake.
module divmod #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] qi,
  input  logic [WIDTH-1:0] ri,
  output logic [WIDTH-1:0] qo,
  output logic [WIDTH-1:0] ro
);

  // The shifted remainder keeps its top bit in a WIDTH+1 intermediate so that
  // divisors above 2^(WIDTH-1) still compare and subtract correctly.
  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] r_diff;
  logic           fits;

  // Shift, compare against the divisor, and conditionally subtract.
  always_comb begin
    r_shift = {ri, qi[WIDTH-1]};
    r_diff  = r_shift - {1'b0, b};
    fits    = (r_shift >= {1'b0, b});
    qo      = {qi[WIDTH-2:0], fits};
    ro      = fits ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative unsigned divider: quotient/remainder of a/b using STEPS restoring bit-steps per clock.
// Latency: start accepted at edge N gives done in the cycle after edge N+WIDTH/STEPS.
// Backpressure: start is ignored while busy; a new start is taken in IDLE or in the DONE cycle.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEPS = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int ITERS = WIDTH / STEPS;
  localparam int CW    = $clog2(ITERS) + 1;

  if (!steps_ok(WIDTH, STEPS)) begin : g_bad_steps
    $error("div_iter: STEPS must be 1, 2 or 4 and divide WIDTH");
  end

  state_t           state, state_nxt;
  logic             accept;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_reg, r_reg, b_reg;
  logic             dz_reg;

  logic [WIDTH-1:0] q_chain [0:STEPS];
  logic [WIDTH-1:0] r_chain [0:STEPS];

  assign q_chain[0] = q_reg;
  assign r_chain[0] = r_reg;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    divmod #(.WIDTH(WIDTH)) u_divmod (
      .b  (b_reg),
      .qi (q_chain[i]),
      .ri (r_chain[i]),
      .qo (q_chain[i+1]),
      .ro (r_chain[i+1])
    );
  end

  // Next-state and status decode; start is only honoured outside RUN.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Operand capture, per-cycle bit-steps and iteration counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_reg  <= '0;
      r_reg  <= '0;
      b_reg  <= '0;
      dz_reg <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      q_reg  <= a;
      r_reg  <= '0;
      b_reg  <= b;
      dz_reg <= (b == '0);
      count  <= CW'(ITERS);
    end else if (state == RUN) begin
      q_reg <= q_chain[STEPS];
      r_reg <= r_chain[STEPS];
      count <= count - CW'(1);
    end
  end

  assign quotient  = q_reg;
  assign remainder = r_reg;
  assign div_zero  = dz_reg;

endmodule
